// File: rtl/stg2if_pkg.sv
// stg2if_pkg: shared sizes for the diad fetch stage.
// Optional perf counters are enabled with STG2IF_PERF_EN.
package stg2if_pkg;

  localparam int unsigned DIAD_PC_W    = 24;
  localparam int unsigned DIAD_INSTR_W = 24;
  localparam int unsigned STG2IF_DEPTH = 4;
  localparam int unsigned PERF_W       = 32;

  // Saturating add for event counters.
  function automatic logic [PERF_W-1:0] sat_add(
    input logic [PERF_W-1:0] a,
    input logic [PERF_W-1:0] b
  );
    logic [PERF_W:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[PERF_W] ? '1 : s[PERF_W-1:0];
  endfunction

endpackage

// File: rtl/stg2if_queue.sv
// stg2if_queue: DEPTH-entry first-word-fall-through FIFO
// with synchronous clear and async active-low reset.
module stg2if_queue
  import stg2if_pkg::*;
#(
  parameter int unsigned W     = DIAD_PC_W + DIAD_INSTR_W,
  parameter int unsigned DEPTH = STG2IF_DEPTH,
  localparam int unsigned PW   = $clog2(DEPTH),
  localparam int unsigned CW   = PW + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr,
  input  logic          push,
  input  logic          pop,
  input  logic [W-1:0]  din,
  output logic [W-1:0]  dout,
  output logic [CW-1:0] count
);

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wp;
  logic [PW-1:0] rp;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wp  <= '0;
      rp  <= '0;
      cnt <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (clr) begin
      wp  <= '0;
      rp  <= '0;
      cnt <= '0;
    end else begin
      if (push) begin
        mem[wp] <= din;
        wp      <= wp + 1'b1;
      end
      if (pop) begin
        rp <= rp + 1'b1;
      end
      unique case ({push, pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  assign dout  = mem[rp];
  assign count = cnt;

endmodule

// File: rtl/stg2if_prefetch.sv
// stg2if_prefetch: IF stage, issues imem reads and queues {pc, instr}.
// Define STG2IF_PERF_EN to add stall/drop perf counter ports.
module stg2if_prefetch
  import stg2if_pkg::*;
#(
  parameter int unsigned PC_WIDTH    = DIAD_PC_W,
  parameter int unsigned INSTR_WIDTH = DIAD_INSTR_W,
  parameter int unsigned DEPTH       = STG2IF_DEPTH
) (
  input  logic                   iw_clk,
  input  logic                   iw_rst_n,
  input  logic [PC_WIDTH-1:0]    iw_iaif_pc,
  input  logic                   iw_iaif_valid,
  output logic                   ow_iaif_ready,
  output logic                   ow_imem_en,
  output logic [PC_WIDTH-1:0]    ow_imem_addr,
  input  logic [INSTR_WIDTH-1:0] iw_imem_data,
  output logic                   ow_ifid_valid,
  output logic [PC_WIDTH-1:0]    ow_ifid_pc,
  output logic [INSTR_WIDTH-1:0] ow_ifid_instr,
  input  logic                   iw_ifid_ready,
  input  logic                   iw_flush
`ifdef STG2IF_PERF_EN
  ,
  output logic [PERF_W-1:0]      ow_perf_stall,
  output logic [PERF_W-1:0]      ow_perf_drop
`endif
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;
  localparam int unsigned QW = PC_WIDTH + INSTR_WIDTH;

  logic [CW-1:0]       count;
  logic [CW-1:0]       occ;
  logic                inflight;
  logic [PC_WIDTH-1:0] inflight_pc;
  logic                issue;
  logic                push;
  logic                pop;
  logic [QW-1:0]       q_din;
  logic [QW-1:0]       q_dout;

  // The in-flight read holds a reserved slot, so a return never overflows.
  assign occ   = count + CW'(inflight);
  assign issue = iw_iaif_valid && ow_iaif_ready;
  assign push  = inflight && !iw_flush;
  assign pop   = ow_ifid_valid && iw_ifid_ready;
  assign q_din = {inflight_pc, iw_imem_data};

  assign ow_iaif_ready = iw_rst_n && !iw_flush && (occ < CW'(DEPTH));
  assign ow_imem_en    = issue;
  assign ow_imem_addr  = issue ? iw_iaif_pc : '0;
  assign ow_ifid_valid = (count != '0) && !iw_flush;
  assign ow_ifid_pc    = q_dout[QW-1:INSTR_WIDTH];
  assign ow_ifid_instr = q_dout[INSTR_WIDTH-1:0];

  always_ff @(posedge iw_clk or negedge iw_rst_n) begin
    if (!iw_rst_n) begin
      inflight    <= 1'b0;
      inflight_pc <= '0;
    end else if (iw_flush) begin
      inflight <= 1'b0;
    end else if (issue) begin
      inflight    <= 1'b1;
      inflight_pc <= iw_iaif_pc;
    end else begin
      inflight <= 1'b0;
    end
  end

  stg2if_queue #(
    .W     (QW),
    .DEPTH (DEPTH)
  ) u_queue (
    .clk   (iw_clk),
    .rst_n (iw_rst_n),
    .clr   (iw_flush),
    .push  (push),
    .pop   (pop),
    .din   (q_din),
    .dout  (q_dout),
    .count (count)
  );

`ifdef STG2IF_PERF_EN
  logic [PERF_W-1:0] perf_stall;
  logic [PERF_W-1:0] perf_drop;

  always_ff @(posedge iw_clk or negedge iw_rst_n) begin
    if (!iw_rst_n) begin
      perf_stall <= '0;
      perf_drop  <= '0;
    end else begin
      if (ow_ifid_valid && !iw_ifid_ready) begin
        perf_stall <= sat_add(perf_stall, PERF_W'(1));
      end
      if (iw_flush) begin
        perf_drop <= sat_add(perf_drop, PERF_W'(occ));
      end
    end
  end

  assign ow_perf_stall = perf_stall;
  assign ow_perf_drop  = perf_drop;
`endif

endmodule

// File: tb/tb_stg2if_prefetch.sv
// tb_stg2if_prefetch: directed checks of the IF prefetch stage.
// Builds with or without STG2IF_PERF_EN.
module tb_stg2if_prefetch;

  logic        iw_clk = 1'b0;
  logic        iw_rst_n;
  logic [23:0] iw_iaif_pc;
  logic        iw_iaif_valid;
  logic        ow_iaif_ready;
  logic        ow_imem_en;
  logic [23:0] ow_imem_addr;
  logic [23:0] iw_imem_data = '0;
  logic        ow_ifid_valid;
  logic [23:0] ow_ifid_pc;
  logic [23:0] ow_ifid_instr;
  logic        iw_ifid_ready;
  logic        iw_flush;
`ifdef STG2IF_PERF_EN
  logic [31:0] ow_perf_stall;
  logic [31:0] ow_perf_drop;
`endif

  int n_cmp = 0;
  int n_err = 0;

  stg2if_prefetch dut (
    .iw_clk        (iw_clk),
    .iw_rst_n      (iw_rst_n),
    .iw_iaif_pc    (iw_iaif_pc),
    .iw_iaif_valid (iw_iaif_valid),
    .ow_iaif_ready (ow_iaif_ready),
    .ow_imem_en    (ow_imem_en),
    .ow_imem_addr  (ow_imem_addr),
    .iw_imem_data  (iw_imem_data),
    .ow_ifid_valid (ow_ifid_valid),
    .ow_ifid_pc    (ow_ifid_pc),
    .ow_ifid_instr (ow_ifid_instr),
    .iw_ifid_ready (iw_ifid_ready),
    .iw_flush      (iw_flush)
`ifdef STG2IF_PERF_EN
    ,
    .ow_perf_stall (ow_perf_stall),
    .ow_perf_drop  (ow_perf_drop)
`endif
  );

  always #5 iw_clk = ~iw_clk;

  function automatic logic [23:0] word(input logic [23:0] a);
    return (a * 24'd7) ^ 24'hA5C3E1;
  endfunction

  // Synchronous imem: one-cycle read latency.
  always @(posedge iw_clk) begin
    if (ow_imem_en) iw_imem_data <= word(ow_imem_addr);
  end

  task automatic tick();
    @(posedge iw_clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    logic [23:0] nxt_pc;
    logic [23:0] exp_pc;

    iw_rst_n      = 1'b0;
    iw_iaif_pc    = '0;
    iw_iaif_valid = 1'b0;
    iw_ifid_ready = 1'b1;
    iw_flush      = 1'b0;
    #1;
    chk("rst_valid", ow_ifid_valid, 0);
    chk("rst_pc", ow_ifid_pc, 0);
    chk("rst_instr", ow_ifid_instr, 0);
    chk("rst_en", ow_imem_en, 0);
    chk("rst_addr", ow_imem_addr, 0);
    tick();
    tick();
    @(negedge iw_clk);
    iw_rst_n = 1'b1;
    #1;
    chk("rel_ready", ow_iaif_ready, 1);
    tick();

    // Streaming 0..7 with ID always ready.
    iw_iaif_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      iw_iaif_pc = 24'(i);
      #1;
      chk("str_en", ow_imem_en, 1);
      chk("str_addr", ow_imem_addr, 24'(i));
      chk("str_ready", ow_iaif_ready, 1);
      if (i >= 2) begin
        chk("str_valid", ow_ifid_valid, 1);
        chk("str_pc", ow_ifid_pc, 24'(i - 2));
        chk("str_instr", ow_ifid_instr, word(24'(i - 2)));
      end
      tick();
    end
    iw_iaif_valid = 1'b0;
    #1;
    chk("str_pc6", ow_ifid_pc, 24'h6);
    tick();
    chk("str_pc7", ow_ifid_pc, 24'h7);
    chk("str_v7", ow_ifid_valid, 1);
    tick();
    chk("str_empty", ow_ifid_valid, 0);

    // Back-pressure: fill to DEPTH, then drain in order.
    iw_ifid_ready = 1'b0;
    iw_iaif_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      iw_iaif_pc = 24'h20 + 24'(k);
      #1;
      chk("bp_en", ow_imem_en, 1);
      tick();
    end
    iw_iaif_pc = 24'h24;
    #1;
    chk("bp_full_ready", ow_iaif_ready, 0);
    chk("bp_full_en", ow_imem_en, 0);
    tick();
    chk("bp_ready4", ow_iaif_ready, 0);
    chk("bp_head", ow_ifid_pc, 24'h20);
    iw_iaif_valid = 1'b0;
    iw_ifid_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk("bp_dvalid", ow_ifid_valid, 1);
      chk("bp_dpc", ow_ifid_pc, 24'h20 + 24'(k));
      chk("bp_dinstr", ow_ifid_instr, word(24'h20 + 24'(k)));
      tick();
    end
    chk("bp_empty", ow_ifid_valid, 0);

    // Flush with three queued and one in flight.
    iw_ifid_ready = 1'b0;
    iw_iaif_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      iw_iaif_pc = 24'h10 + 24'(k);
      tick();
    end
    iw_iaif_pc = 24'h14;
    iw_flush   = 1'b1;
    #1;
    chk("fl_ready", ow_iaif_ready, 0);
    chk("fl_valid", ow_ifid_valid, 0);
    chk("fl_en", ow_imem_en, 0);
    tick();
    iw_flush      = 1'b0;
    iw_ifid_ready = 1'b1;
    iw_iaif_pc    = 24'h40;
    #1;
    chk("fl_post_valid", ow_ifid_valid, 0);
    chk("fl_post_en", ow_imem_en, 1);
`ifdef STG2IF_PERF_EN
    chk("fl_perf_drop", ow_perf_drop, 32'd4);
`endif
    tick();
    iw_iaif_valid = 1'b0;
    #1;
    chk("fl_wait_valid", ow_ifid_valid, 0);
    tick();
    chk("fl_new_valid", ow_ifid_valid, 1);
    chk("fl_new_pc", ow_ifid_pc, 24'h40);
    chk("fl_new_instr", ow_ifid_instr, word(24'h40));
    tick();
    chk("fl_empty", ow_ifid_valid, 0);

    // Push+pop at count=3/inflight=1, then stream across pointer wrap.
    iw_ifid_ready = 1'b0;
    iw_iaif_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      iw_iaif_pc = 24'h50 + 24'(k);
      tick();
    end
    iw_ifid_ready = 1'b1;
    iw_iaif_pc    = 24'h54;
    #1;
    chk("pp_ready", ow_iaif_ready, 0);
    chk("pp_valid", ow_ifid_valid, 1);
    tick();
    chk("pp_after_ready", ow_iaif_ready, 1);
    chk("pp_after_pc", ow_ifid_pc, 24'h51);
    nxt_pc = 24'h54;
    exp_pc = 24'h51;
    for (int c = 0; c < 60 && exp_pc < 24'h5E; c++) begin
      iw_iaif_pc    = nxt_pc;
      iw_iaif_valid = (nxt_pc < 24'h5E);
      #1;
      if (ow_ifid_valid) begin
        chk("wr_pc", ow_ifid_pc, exp_pc);
        chk("wr_instr", ow_ifid_instr, word(exp_pc));
        exp_pc++;
      end
      if (ow_imem_en) nxt_pc++;
      tick();
    end
    chk("wr_total", exp_pc, 24'h5E);
    iw_iaif_valid = 1'b0;
    #1;
    chk("wr_empty", ow_ifid_valid, 0);

    // Async reset mid-stream.
    iw_ifid_ready = 1'b0;
    iw_iaif_valid = 1'b1;
    iw_iaif_pc    = 24'h60;
    tick();
    iw_iaif_pc = 24'h61;
    tick();
    chk("ar_pre_valid", ow_ifid_valid, 1);
    #2;
    iw_rst_n = 1'b0;
    #1;
    chk("ar_valid", ow_ifid_valid, 0);
    chk("ar_pc", ow_ifid_pc, 0);
    chk("ar_instr", ow_ifid_instr, 0);
    chk("ar_en", ow_imem_en, 0);
    chk("ar_addr", ow_imem_addr, 0);
    tick();
    @(negedge iw_clk);
    iw_rst_n      = 1'b1;
    iw_ifid_ready = 1'b1;
    iw_iaif_pc    = 24'h0;
    #1;
    chk("ar_rel_en", ow_imem_en, 1);
    tick();
    iw_iaif_valid = 1'b0;
    tick();
    chk("ar_first_valid", ow_ifid_valid, 1);
    chk("ar_first_pc", ow_ifid_pc, 24'h0);
    chk("ar_first_instr", ow_ifid_instr, word(24'h0));
    tick();

    // Idle.
    for (int k = 0; k < 5; k++) begin
      #1;
      chk("idle_en", ow_imem_en, 0);
      chk("idle_valid", ow_ifid_valid, 0);
`ifdef STG2IF_PERF_EN
      chk("idle_stall", ow_perf_stall, 32'd0);
`endif
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
